// File: rtl/debug_loader.sv
// Host debug loader: assembles UART bytes into words for IF memory, then runs or single-steps the pipeline.
// Latency: the write pulse comes 1 cycle after the 4th byte; o_halt follows 'R'/'S' by 1 cycle; o_tx_start is combinational in ACK.
// Backpressure: waits in ACK while i_tx_busy is high; bytes received outside IDLE/LOAD are dropped.
// Optional feature macro: DEBUG_LOADER_TIMEOUT_EN enables an inter-byte timeout while in LOAD.
module debug_loader #(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 32,
    parameter int IMEM_DEPTH     = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_pipe_halted,
    input  logic               i_tx_busy,
    output logic [NB_DATA-1:0] o_instruction_data,
    output logic [NB_ADDR-1:0] o_inst_addr,
    output logic               o_we_IF,
    output logic               o_halt,
    output logic               o_pipe_rst,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;
    localparam logic [7:0] RSP_STEP = 8'h2E;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP,
        S_ACK
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [1:0]           bcnt_q, bcnt_d;
    // first three bytes of the word being assembled; the 4th byte goes straight to the output register
    logic [NB_DATA-9:0]   part_q, part_d;
    logic                 last_q, last_d;
    logic                 we_q, we_d;
    logic [NB_DATA-1:0]   data_q, data_d;
    logic [NB_ADDR-1:0]   addr_q, addr_d;
    logic                 halt_q, halt_d;
    logic                 prst_q, prst_d;
    logic [7:0]           txd_q, txd_d;
    logic                 is_halt_word;

    // top six opcode bits all ones marks the HALT instruction
    assign is_halt_word = (data_q[NB_DATA-1 -: 6] == 6'b111111);

`ifdef DEBUG_LOADER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // inter-byte idle counter: runs only in LOAD and restarts on every received byte
    always_comb begin
        tmo_d = '0;
        if (state_q == S_LOAD && !i_rx_valid) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // timeout counter register
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // next-state and next-output computation for the whole controller
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        part_d  = part_q;
        last_d  = last_q;
        we_d    = 1'b0;
        data_d  = data_q;
        addr_d  = addr_q;
        halt_d  = halt_q;
        prst_d  = 1'b0;
        txd_d   = txd_q;

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d = S_LOAD;
                            idx_d   = '0;
                            bcnt_d  = '0;
                        end
                        CMD_RUN: begin
                            // an already-halted pipeline is never released
                            if (i_pipe_halted) begin
                                state_d = S_ACK;
                                txd_d   = RSP_ACK;
                            end else begin
                                state_d = S_RUN;
                                halt_d  = 1'b0;
                            end
                        end
                        CMD_STEP: begin
                            if (i_pipe_halted) begin
                                state_d = S_ACK;
                                txd_d   = RSP_STEP;
                            end else begin
                                state_d = S_STEP;
                                halt_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_LOAD: begin
                if (we_q && (is_halt_word || last_q)) begin
                    // program complete (HALT) or memory full: reset the pipeline and report
                    state_d = S_ACK;
                    prst_d  = 1'b1;
                    bcnt_d  = '0;
                    txd_d   = is_halt_word ? RSP_ACK : RSP_NAK;
                end else begin
                    if (we_q) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (i_rx_valid) begin
                        case (bcnt_q)
                            2'd0: part_d[NB_DATA-9  -: 8] = i_rx_data;
                            2'd1: part_d[NB_DATA-17 -: 8] = i_rx_data;
                            2'd2: part_d[7:0]             = i_rx_data;
                            default: begin
                                we_d   = 1'b1;
                                data_d = {part_q, i_rx_data};
                                addr_d = NB_ADDR'(idx_q) << 2;
                                last_d = (idx_q == IW'(IMEM_DEPTH - 1));
                            end
                        endcase
                        bcnt_d = bcnt_q + 1'b1;
                    end
`ifdef DEBUG_LOADER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        // host went silent: drop the partial word without writing it
                        state_d = S_ACK;
                        bcnt_d  = '0;
                        txd_d   = RSP_NAK;
                    end
`endif
                end
            end

            S_RUN: begin
                if (i_pipe_halted) begin
                    halt_d  = 1'b1;
                    state_d = S_ACK;
                    txd_d   = RSP_ACK;
                end
            end

            S_STEP: begin
                // release lasts exactly one cycle
                halt_d  = 1'b1;
                state_d = S_ACK;
                txd_d   = RSP_STEP;
            end

            S_ACK: begin
                if (!i_tx_busy) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                halt_d  = 1'b1;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bcnt_q  <= '0;
            part_q  <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            halt_q  <= 1'b1;
            prst_q  <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            part_q  <= part_d;
            last_q  <= last_d;
            we_q    <= we_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            halt_q  <= halt_d;
            prst_q  <= prst_d;
            txd_q   <= txd_d;
        end
    end

    assign o_instruction_data = data_q;
    assign o_inst_addr        = addr_q;
    assign o_we_IF            = we_q;
    assign o_halt             = halt_q;
    assign o_pipe_rst         = prst_q;
    assign o_tx_data          = txd_q;
    assign o_tx_start         = (state_q == S_ACK) && !i_tx_busy;
    assign o_busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_loader.sv
// Testbench for debug_loader: table of host commands plus hand sequences for run, reset, timeout and TX stall.
// Latency: outputs are observed on the falling edge, half a cycle after the rising edge that updates them.
// Backpressure: i_tx_busy is held low except in the dedicated stall sequence.
module tb_debug_loader;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_pipe_halted;
    logic        i_tx_busy;
    logic [31:0] o_instruction_data;
    logic [31:0] o_inst_addr;
    logic        o_we_IF;
    logic        o_halt;
    logic        o_pipe_rst;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;

    debug_loader #(
        .NB_DATA(32), .NB_ADDR(32), .IMEM_DEPTH(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .i_rst(i_rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .i_pipe_halted(i_pipe_halted), .i_tx_busy(i_tx_busy),
        .o_instruction_data(o_instruction_data), .o_inst_addr(o_inst_addr),
        .o_we_IF(o_we_IF), .o_halt(o_halt), .o_pipe_rst(o_pipe_rst),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // event recorder, cumulative over the whole run
    logic [31:0] we_addr [0:63];
    logic [31:0] we_dat  [0:63];
    int          we_n   = 0;
    int          prst_n = 0;
    int          tx_n   = 0;
    int          low_n  = 0;
    logic [7:0]  tx_last = 8'h00;

    always @(negedge clk) begin
        if (o_we_IF && we_n < 64) begin
            we_addr[we_n[5:0]] <= o_inst_addr;
            we_dat[we_n[5:0]]  <= o_instruction_data;
            we_n <= we_n + 1;
        end
        if (o_pipe_rst) prst_n <= prst_n + 1;
        if (o_tx_start) begin
            tx_n    <= tx_n + 1;
            tx_last <= o_tx_data;
        end
        if (!o_halt) low_n <= low_n + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int s_we, s_prst, s_tx, s_low;

    typedef struct {
        logic [7:0]  cmd;
        int          nw;
        logic [31:0] w0, w1, w2, w3;
        logic        pipe_hi;
        int          exp_we;
        int          exp_txn;
        logic [7:0]  exp_tx;
        int          exp_prst;
        int          exp_low;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] get_w(input vec_t v, input int k);
        case (k)
            0:       return v.w0;
            1:       return v.w1;
            2:       return v.w2;
            default: return v.w3;
        endcase
    endfunction

    task automatic snap();
        s_we = we_n; s_prst = prst_n; s_tx = tx_n; s_low = low_n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if (!o_busy) break;
            @(negedge clk);
            cycles++;
        end
        check("idle_within_budget", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input int r, input vec_t v);
        int c;
        i_pipe_halted = v.pipe_hi;
        @(negedge clk);
        snap();
        send_byte(v.cmd);
        for (int k = 0; k < v.nw; k++) send_word(get_w(v, k));
        wait_idle(200, c);
        repeat (3) @(negedge clk);
        i_pipe_halted = 1'b0;
        check($sformatf("row%0d_we_count", r), we_n - s_we, v.exp_we);
        for (int k = 0; k < v.exp_we && k < we_n - s_we; k++) begin
            check($sformatf("row%0d_addr%0d", r, k), we_addr[6'(s_we + k)], 32'(k * 4));
            check($sformatf("row%0d_data%0d", r, k), we_dat[6'(s_we + k)], get_w(v, k));
        end
        check($sformatf("row%0d_tx_count", r), tx_n - s_tx, v.exp_txn);
        if (v.exp_txn > 0) check($sformatf("row%0d_tx_byte", r), {24'd0, tx_last}, {24'd0, v.exp_tx});
        check($sformatf("row%0d_pipe_rst", r), prst_n - s_prst, v.exp_prst);
        check($sformatf("row%0d_halt_low", r), low_n - s_low, v.exp_low);
        check($sformatf("row%0d_halt_end", r), {31'd0, o_halt}, 32'd1);
    endtask

    initial begin
        int c;
        tbl[0]  = '{8'h4C, 2, 32'h2001000F, 32'hFC000000, 32'h0, 32'h0, 1'b0, 2, 1, 8'h06, 1, 0};
        tbl[1]  = '{8'h4C, 4, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 4, 1, 8'h15, 1, 0};
        tbl[2]  = '{8'h4C, 2, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 2, 1, 8'h06, 1, 0};
        tbl[3]  = '{8'h4C, 4, 32'h0000000A, 32'h0000000B, 32'h0000000C, 32'hFC000001, 1'b0, 4, 1, 8'h06, 1, 0};
        tbl[4]  = '{8'h53, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1, 8'h2E, 0, 1};
        tbl[5]  = '{8'h53, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1, 8'h2E, 0, 1};
        tbl[6]  = '{8'h53, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1, 8'h2E, 0, 1};
        tbl[7]  = '{8'h53, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 1, 8'h2E, 0, 0};
        tbl[8]  = '{8'h52, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 1, 8'h06, 0, 0};
        tbl[9]  = '{8'h41, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 8'h00, 0, 0};
        tbl[10] = '{8'h06, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 8'h00, 0, 0};

        i_rst = 1'b1; i_rx_data = 8'h00; i_rx_valid = 1'b0;
        i_pipe_halted = 1'b0; i_tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",     o_instruction_data, 32'h0);
        check("rst_addr",     o_inst_addr, 32'h0);
        check("rst_we",       {31'd0, o_we_IF}, 32'd0);
        check("rst_halt",     {31'd0, o_halt}, 32'd1);
        check("rst_pipe_rst", {31'd0, o_pipe_rst}, 32'd0);
        check("rst_tx_data",  {24'd0, o_tx_data}, 32'd0);
        check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_busy",     {31'd0, o_busy}, 32'd0);
        i_rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 11; r++) run_vec(r, tbl[r]);

        // RUN: pipeline reports halt 20 cycles after 'R'
        snap();
        i_rx_data = 8'h52; i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat (19) @(negedge clk);
        i_pipe_halted = 1'b1;
        wait_idle(50, c);
        repeat (3) @(negedge clk);
        i_pipe_halted = 1'b0;
        check("run_low_cycles", low_n - s_low, 20);
        check("run_tx_count",   tx_n - s_tx, 1);
        check("run_tx_byte",    {24'd0, tx_last}, 32'h06);
        check("run_halt_end",   {31'd0, o_halt}, 32'd1);
        check("run_no_prst",    prst_n - s_prst, 0);

        // full memory without HALT, then a fifth word that must fall on IDLE
        snap();
        send_byte(8'h4C);
        for (int k = 0; k < 4; k++) send_word(32'h01000000 + k);
        send_word(32'h55667788);
        wait_idle(50, c);
        repeat (3) @(negedge clk);
        check("full_we_count", we_n - s_we, 4);
        check("full_last_addr", we_addr[6'(s_we + 3)], 32'hC);
        check("full_tx_byte",  {24'd0, tx_last}, 32'h15);
        check("full_tx_count", tx_n - s_tx, 1);

        // reset in the middle of a word
        snap();
        send_byte(8'h4C);
        send_byte(8'h12);
        send_byte(8'h34);
        i_rst = 1'b1;
        @(negedge clk);
        check("midrst_halt", {31'd0, o_halt}, 32'd1);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_we", we_n - s_we, 0);
        snap();
        send_byte(8'h4C);
        send_word(32'hFC000000);
        wait_idle(50, c);
        repeat (3) @(negedge clk);
        check("reload_we_count", we_n - s_we, 1);
        check("reload_addr", we_addr[6'(s_we)], 32'h0);
        check("reload_data", we_dat[6'(s_we)], 32'hFC000000);
        check("reload_tx",   {24'd0, tx_last}, 32'h06);

        // TX stalled: ACK must hold until i_tx_busy drops
        i_tx_busy = 1'b1;
        snap();
        send_byte(8'h53);
        repeat (10) @(negedge clk);
        check("stall_busy",     {31'd0, o_busy}, 32'd1);
        check("stall_no_start", tx_n - s_tx, 0);
        check("stall_tx_data",  {24'd0, o_tx_data}, 32'h2E);
        i_tx_busy = 1'b0;
        wait_idle(20, c);
        repeat (3) @(negedge clk);
        check("stall_tx_count", tx_n - s_tx, 1);

        // silence after three bytes of a word
        snap();
        send_byte(8'h4C);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
`ifdef DEBUG_LOADER_TIMEOUT_EN
        wait_idle(300, c);
        repeat (3) @(negedge clk);
        check("tmo_tx_count", tx_n - s_tx, 1);
        check("tmo_tx_byte",  {24'd0, tx_last}, 32'h15);
        check("tmo_no_we",    we_n - s_we, 0);
        check("tmo_no_prst",  prst_n - s_prst, 0);
        check("tmo_delay_ok", {31'd0, (c >= 90 && c <= 105)}, 32'd1);
`else
        repeat (200) @(negedge clk);
        check("notmo_busy",   {31'd0, o_busy}, 32'd1);
        check("notmo_no_we",  we_n - s_we, 0);
        check("notmo_no_tx",  tx_n - s_tx, 0);
        do_reset();
        check("notmo_rst_idle", {31'd0, o_busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
